// File: rtl/retospect_bitstream_loader.sv
// Config-chain writer: takes bytes over valid/ready, shifts them LSB-first onto the chain for CHAIN_LEN cycles.
// Optional readback CRC of the chain tail when RETOSPECT_LOADER_READBACK_EN is defined.
module retospect_bitstream_loader #(
  parameter int CHAIN_LEN = 498
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [7:0] byte_in_i,
  input  logic       byte_valid_i,
  output logic       byte_ready_o,
  output logic       config_en_o,
  output logic       bs_out_o,
  input  logic       bs_ret_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       underrun_o,
  output logic [7:0] rb_crc_o
);
  localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int NBYTES = (CHAIN_LEN + 7) / 8;
  localparam int BC_W   = $clog2(NBYTES + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       sh_q, sh_d, buf_q, buf_d;
  logic [3:0]       sh_cnt_q, sh_cnt_d;
  logic             buf_full_q, buf_full_d;
  logic [CNT_W-1:0] bits_left_q, bits_left_d;
  logic [BC_W-1:0]  bytes_acc_q, bytes_acc_d;
  logic             config_en_q, config_en_d;
  logic             bs_out_q, bs_out_d;
  logic             underrun_q, underrun_d;
  logic             accept, use_in;
  logic [7:0]       src_data;
  logic [3:0]       src_cnt;

  assign byte_ready_o = (state_q == S_LOAD) && !buf_full_q &&
                        (bytes_acc_q < BC_W'(NBYTES));
  assign accept       = byte_ready_o && byte_valid_i;

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    sh_cnt_d    = sh_cnt_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    bits_left_d = bits_left_q;
    bytes_acc_d = bytes_acc_q;
    underrun_d  = underrun_q;
    config_en_d = 1'b0;
    bs_out_d    = 1'b0;
    src_data    = 8'h00;
    src_cnt     = 4'd0;
    use_in      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d     = S_LOAD;
          bits_left_d = CNT_W'(CHAIN_LEN);
          sh_cnt_d    = 4'd0;
          buf_full_d  = 1'b0;
          bytes_acc_d = '0;
          underrun_d  = 1'b0;
        end
      end
      S_LOAD: begin
        if (accept) bytes_acc_d = bytes_acc_q + BC_W'(1);
        // Bit source priority: current shift byte, then buffer, then the byte arriving now.
        if (sh_cnt_q != 4'd0) begin
          src_data = sh_q;
          src_cnt  = sh_cnt_q;
        end else if (buf_full_q) begin
          src_data   = buf_q;
          src_cnt    = 4'd8;
          buf_full_d = 1'b0;
        end else if (accept) begin
          src_data = byte_in_i;
          src_cnt  = 4'd8;
          use_in   = 1'b1;
        end
        if (accept && !use_in) begin
          buf_d      = byte_in_i;
          buf_full_d = 1'b1;
        end
        if (bits_left_q == '0) begin
          state_d = S_DONE;
        end else if (src_cnt != 4'd0) begin
          config_en_d = 1'b1;
          bs_out_d    = src_data[0];
          sh_d        = {1'b0, src_data[7:1]};
          sh_cnt_d    = src_cnt - 4'd1;
          bits_left_d = bits_left_q - CNT_W'(1);
        end else if (bytes_acc_q != '0) begin
          // Waiting for the very first byte is not a starvation event.
          underrun_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      sh_q        <= 8'h00;
      sh_cnt_q    <= 4'd0;
      buf_q       <= 8'h00;
      buf_full_q  <= 1'b0;
      bits_left_q <= '0;
      bytes_acc_q <= '0;
      config_en_q <= 1'b0;
      bs_out_q    <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      sh_cnt_q    <= sh_cnt_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      bits_left_q <= bits_left_d;
      bytes_acc_q <= bytes_acc_d;
      config_en_q <= config_en_d;
      bs_out_q    <= bs_out_d;
      underrun_q  <= underrun_d;
    end
  end

  assign config_en_o = config_en_q;
  assign bs_out_o    = bs_out_q;
  assign busy_o      = (state_q == S_LOAD);
  assign done_o      = (state_q == S_DONE);
  assign underrun_o  = underrun_q;

`ifdef RETOSPECT_LOADER_READBACK_EN
  logic [7:0] crc_q;

  // The tail bit is sampled before the chain shifts on each config_en cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      crc_q <= 8'h00;
    end else if (state_q == S_IDLE && start_i) begin
      crc_q <= 8'h00;
    end else if (config_en_q) begin
      crc_q <= {crc_q[6:0], 1'b0} ^ ({8{crc_q[7] ^ bs_ret_i}} & 8'h07);
    end
  end

  assign rb_crc_o = crc_q;
`else
  logic unused_bs_ret;
  assign unused_bs_ret = bs_ret_i;
  assign rb_crc_o      = 8'h00;
`endif

endmodule
